risc_v_mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port unified RISC-V memory between the instruction-fetch requester (port I) and the load/store requester (port D). It is used by the multi-cycle core and sits between the core's control/datapath and the memory instance. It serialises accesses with a three-state FSM, applies round-robin priority on contention, and returns registered read data with a one-cycle acknowledge pulse.

---
 rtl/risc_v_mem_arb_pkg.sv | 17 +
 rtl/risc_v_rr_picker2.sv | 29 ++
 rtl/risc_v_mem_arbiter.sv | 116 +++++++++++
 tb/tb_risc_v_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mem_arb_pkg.sv
// Shared types for the unified-memory arbiter:
// FSM states, port owner codes and default widths.
package risc_v_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/risc_v_rr_picker2.sv
// Two-way round-robin select: on a tie the port
// that did not own the previous access wins.
module risc_v_rr_picker2
   import risc_v_mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic last_owner,
   output logic gnt,
   output logic owner
);

   logic both;
   logic d_only;

   assign both   = i_req & d_req;
   assign d_only = d_req & ~i_req;

   always_comb begin
      gnt   = i_req | d_req;
      owner = OWN_I;
      unique case (1'b1)
         both:    owner = ~last_owner;
         d_only:  owner = OWN_D;
         default: owner = OWN_I;
      endcase
   end

endmodule

// File: rtl/risc_v_mem_arbiter.sv
// Serialises fetch (I) and load/store (D) accesses
// onto the single-port unified memory.
module risc_v_mem_arbiter
   import risc_v_mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   state_t            state;
   state_t            nxt;
   logic              owner;
   logic              last_owner;
   logic [ADDR_W-1:0] a_addr;
   logic              a_we;
   logic [DATA_W-1:0] a_wdata;
   logic              gnt;
   logic              pick;
   logic              take;

   risc_v_rr_picker2 u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .last_owner (last_owner),
      .gnt        (gnt),
      .owner      (pick)
   );

   assign take = (state == IDLE) && gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (gnt) nxt = ACCESS;
         ACCESS:  nxt = RESP;
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Request fields are frozen at grant time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_I;
         last_owner <= OWN_D;
         a_addr     <= '0;
         a_we       <= 1'b0;
         a_wdata    <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         if (take) begin
            owner <= pick;
            if (pick == OWN_D) begin
               a_addr  <= d_addr;
               a_we    <= d_we;
               a_wdata <= d_wdata;
            end else begin
               a_addr  <= i_addr;
               a_we    <= 1'b0;
               a_wdata <= '0;
            end
         end
         if (state == ACCESS) begin
            last_owner <= owner;
            if (owner == OWN_D) d_rdata <= mem_dout;
            else                i_rdata <= mem_dout;
         end
      end
   end

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      i_ack    = 1'b0;
      d_ack    = 1'b0;
      busy     = (state != IDLE);
      unique case (state)
         ACCESS: begin
            mem_addr = a_addr;
            mem_din  = a_wdata;
            mem_we   = a_we;
         end
         RESP: begin
            i_ack = (owner == OWN_I);
            d_ack = (owner == OWN_D);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_risc_v_mem_arbiter.sv
// Directed bench for risc_v_mem_arbiter with a
// small word memory model behind the mem port.
module tb_risc_v_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        mem_we;
   logic [31:0] mem_dout;
   logic        busy;

   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   risc_v_mem_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_ack    (i_ack),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack),
      .d_rdata  (d_rdata),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .mem_dout (mem_dout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int k = 0; k < 64; k++)
         mem[k] <= 32'h1000_0000 + k;
   end

   always @(posedge clk)
      if (mem_we) mem[mem_addr[7:2]] <= mem_din;

   assign mem_dout = mem[mem_addr[7:2]];

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_iack", {31'd0, i_ack}, 32'd0);
      chk("rst_dack", {31'd0, d_ack}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_din", mem_din, 32'd0);
      chk("rst_irdata", i_rdata, 32'd0);
      chk("rst_drdata", d_rdata, 32'd0);
      rst = 1'b0;
      tick();

      // single I read
      i_req  = 1'b1;
      i_addr = 32'h8;
      tick();
      chk("i1_addr", mem_addr, 32'h8);
      chk("i1_busy", {31'd0, busy}, 32'd1);
      chk("i1_we", {31'd0, mem_we}, 32'd0);
      chk("i1_ack_c1", {31'd0, i_ack}, 32'd0);
      chk("i1_dack_c1", {31'd0, d_ack}, 32'd0);
      tick();
      chk("i1_ack_c2", {31'd0, i_ack}, 32'd1);
      chk("i1_dack_c2", {31'd0, d_ack}, 32'd0);
      chk("i1_rdata", i_rdata, 32'h1000_0002);
      i_req = 1'b0;
      tick();
      chk("i1_idle", {31'd0, busy}, 32'd0);

      // D write then read back
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h10;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      chk("dw_we", {31'd0, mem_we}, 32'd1);
      chk("dw_addr", mem_addr, 32'h10);
      chk("dw_din", mem_din, 32'hDEAD_BEEF);
      tick();
      chk("dw_ack", {31'd0, d_ack}, 32'd1);
      chk("dw_iack", {31'd0, i_ack}, 32'd0);
      chk("dw_we_resp", {31'd0, mem_we}, 32'd0);
      chk("dw_old", d_rdata, 32'h1000_0004);
      chk("dw_mem", mem[4], 32'hDEAD_BEEF);
      d_we = 1'b0;
      tick();
      chk("dr_c3_ack", {31'd0, d_ack}, 32'd0);
      tick();
      chk("dr_c4_we", {31'd0, mem_we}, 32'd0);
      tick();
      chk("dr_ack", {31'd0, d_ack}, 32'd1);
      chk("dr_rdata", d_rdata, 32'hDEAD_BEEF);
      chk("dr_irdata", i_rdata, 32'h1000_0002);
      d_req = 1'b0;
      tick();

      // contention with both held: I, D, I
      i_req  = 1'b1;
      i_addr = 32'h0;
      d_req  = 1'b1;
      d_addr = 32'h4;
      for (int c = 0; c < 9; c++) begin
         chk($sformatf("rr_iack_c%0d", c), {31'd0, i_ack},
             {31'd0, (c == 2) || (c == 8)});
         chk($sformatf("rr_dack_c%0d", c), {31'd0, d_ack},
             {31'd0, c == 5});
         if (c == 2) chk("rr_irdata", i_rdata, 32'h1000_0000);
         if (c == 5) chk("rr_drdata", d_rdata, 32'h1000_0001);
         if (c == 8) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         tick();
      end

      // inputs change during ACCESS
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h14;
      d_wdata = 32'h1234_5678;
      tick();
      d_addr  = 32'h18;
      d_wdata = 32'hBAD0_BAD0;
      #1;
      chk("chg_addr", mem_addr, 32'h14);
      chk("chg_din", mem_din, 32'h1234_5678);
      tick();
      chk("chg_ack", {31'd0, d_ack}, 32'd1);
      chk("chg_mem5", mem[5], 32'h1234_5678);
      chk("chg_mem6", mem[6], 32'h1000_0006);
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();

      // reset in the middle of a write
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'hCAFE_F00D;
      tick();
      chk("rw_we_pre", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rw_we", {31'd0, mem_we}, 32'd0);
      chk("rw_busy", {31'd0, busy}, 32'd0);
      chk("rw_addr", mem_addr, 32'd0);
      tick();
      chk("rw_mem", mem[8], 32'h1000_0008);
      chk("rw_dack", {31'd0, d_ack}, 32'd0);
      chk("rw_drdata", d_rdata, 32'd0);
      rst   = 1'b0;
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
      chk("rw_dack2", {31'd0, d_ack}, 32'd0);
      chk("rw_busy2", {31'd0, busy}, 32'd0);

      // idle stretch
      for (int c = 0; c < 10; c++) begin
         chk("idle_busy", {31'd0, busy}, 32'd0);
         chk("idle_we", {31'd0, mem_we}, 32'd0);
         chk("idle_iack", {31'd0, i_ack}, 32'd0);
         chk("idle_dack", {31'd0, d_ack}, 32'd0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
